// File: rtl/vga_scan_out_if.sv
// Pixel FIFO read port between the VGA scan-out engine and the show-ahead FIFO.
//   fifo_rdata  : head word, RGB565 (R[15:11] G[10:5] B[4:0]), valid when !fifo_rempty
//   fifo_rempty : FIFO empty
//   fifo_rfull  : FIFO full
//   fifo_read   : pop strobe from the scan-out engine
// master = scan-out engine (consumer), slave = FIFO side.
interface vga_scan_out_if;
  logic [15:0] fifo_rdata;
  logic        fifo_rempty;
  logic        fifo_rfull;
  logic        fifo_read;

  modport master (
    input  fifo_rdata,
    input  fifo_rempty,
    input  fifo_rfull,
    output fifo_read
  );

  modport slave (
    output fifo_rdata,
    output fifo_rempty,
    output fifo_rfull,
    input  fifo_read
  );
endinterface

// File: rtl/vga_scan_out.sv
// VGA scan-out back end (pixel clock domain).
// Generates raster timing and pops one RGB565 word per active pixel from the
// pixel FIFO. After an underflow it stops popping until the FIFO reports full
// again, then resynchronises at the next frame start.
// Ports:
//   fpga_CLK_AUX : pixel clock
//   n_rst        : asynchronous active-low reset
//   fifo         : FIFO read port (master side; fifo_read is combinational)
//   vga_HS/VS    : active-low syncs, registered
//   vga_BLANK    : 1 = active video, registered
//   vga_R/G/B    : 8-bit colour, RGB565 expanded by MSB replication
//   frame_start  : 1-cycle pulse when the raster is at pixel (0,0)
//   underflow    : sticky underflow flag, cleared only by reset
module vga_scan_out #(
  parameter int HDISP  = 640,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VDISP  = 480,
  parameter int VFP    = 11,
  parameter int VPULSE = 2,
  parameter int VBP    = 31
) (
  input  logic                 fpga_CLK_AUX,
  input  logic                 n_rst,
  vga_scan_out_if.master       fifo,
  output logic                 vga_HS,
  output logic                 vga_VS,
  output logic                 vga_BLANK,
  output logic [7:0]           vga_R,
  output logic [7:0]           vga_G,
  output logic [7:0]           vga_B,
  output logic                 frame_start,
  output logic                 underflow
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_DISP   = HW'(HDISP);
  localparam logic [VW-1:0] V_DISP   = VW'(VDISP);
  localparam logic [HW-1:0] HS_START = HW'(HDISP + HFP);
  localparam logic [HW-1:0] HS_END   = HW'(HDISP + HFP + HPULSE);
  localparam logic [VW-1:0] VS_START = VW'(VDISP + VFP);
  localparam logic [VW-1:0] VS_END   = VW'(VDISP + VFP + VPULSE);

  localparam logic [1:0] WAIT_FULL = 2'd0;
  localparam logic [1:0] WAIT_SOF  = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  // RGB565 channel expansion to 8 bits by replicating the MSBs into the LSBs,
  // so full-scale codes map to 8'hFF and zero stays zero.
  function automatic logic [7:0] expand5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] expand6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    state;

  // ---- stage p0: raster decode and pop decision from the current counters ----
  logic active_p0;
  logic hs_n_p0;
  logic vs_n_p0;
  logic last_pos_p0;
  logic vld_p0;

  assign active_p0   = (hcnt < H_DISP) && (vcnt < V_DISP);
  assign hs_n_p0     = !((hcnt >= HS_START) && (hcnt < HS_END));
  assign vs_n_p0     = !((vcnt >= VS_START) && (vcnt < VS_END));
  assign last_pos_p0 = (hcnt == H_LAST) && (vcnt == V_LAST);
  // Pop only in RUN, on active pixels, and only when the head word is valid.
  assign vld_p0      = (state == RUN) && active_p0 && !fifo.fifo_rempty;
  assign fifo.fifo_read = vld_p0;

  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // A frame end seen in WAIT_FULL does not skip WAIT_SOF: RUN always begins
  // at a frame start that follows a full FIFO, so every frame starts aligned.
  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      state     <= WAIT_FULL;
      underflow <= 1'b0;
    end else begin
      case (state)
        WAIT_FULL: if (fifo.fifo_rfull) state <= WAIT_SOF;
        WAIT_SOF:  if (last_pos_p0) state <= RUN;
        RUN: begin
          if (active_p0 && fifo.fifo_rempty) begin
            state     <= WAIT_FULL;
            underflow <= 1'b1;
          end
        end
        default:   state <= WAIT_FULL;
      endcase
    end
  end

  // ---- stage p1: registered pin outputs, one cycle behind the counters ----
  always_ff @(posedge fpga_CLK_AUX or negedge n_rst) begin
    if (!n_rst) begin
      vga_HS      <= 1'b1;
      vga_VS      <= 1'b1;
      vga_BLANK   <= 1'b0;
      vga_R       <= 8'd0;
      vga_G       <= 8'd0;
      vga_B       <= 8'd0;
      frame_start <= 1'b0;
    end else begin
      vga_HS      <= hs_n_p0;
      vga_VS      <= vs_n_p0;
      vga_BLANK   <= active_p0;
      frame_start <= last_pos_p0;
      if (vld_p0) begin
        vga_R <= expand5(fifo.fifo_rdata[15:11]);
        vga_G <= expand6(fifo.fifo_rdata[10:5]);
        vga_B <= expand5(fifo.fifo_rdata[4:0]);
      end else begin
        vga_R <= 8'd0;
        vga_G <= 8'd0;
        vga_B <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_out.sv
module tb_vga_scan_out;

  localparam int HDISP = 4, HFP = 1, HPULSE = 2, HBP = 1;
  localparam int VDISP = 3, VFP = 1, VPULSE = 1, VBP = 1;
  localparam int HT = HDISP + HFP + HPULSE + HBP;  // 8
  localparam int VT = VDISP + VFP + VPULSE + VBP;  // 6
  localparam int FR = HT * VT;                     // 48

  logic       clk;
  logic       n_rst;
  logic       vga_HS, vga_VS, vga_BLANK, frame_start, underflow;
  logic [7:0] vga_R, vga_G, vga_B;

  vga_scan_out_if intf ();

  vga_scan_out #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .fpga_CLK_AUX(clk),
    .n_rst       (n_rst),
    .fifo        (intf.master),
    .vga_HS      (vga_HS),
    .vga_VS      (vga_VS),
    .vga_BLANK   (vga_BLANK),
    .vga_R       (vga_R),
    .vga_G       (vga_G),
    .vga_B       (vga_B),
    .frame_start (frame_start),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The raster is a single frame position 0..FR-1; line/pixel are derived
  // arithmetically. mode: 0 = waiting for a full FIFO, 1 = armed, waiting
  // for the frame to end, 2 = streaming pixels.
  int         m_pos;
  int         m_mode;
  logic       e_hs, e_vs, e_blank, e_fs, e_uf;
  logic [7:0] e_r, e_g, e_b;

  function automatic bit is_act(input int p);
    return ((p % HT) < HDISP) && ((p / HT) < VDISP);
  endfunction

  function automatic bit in_hs(input int p);
    return ((p % HT) >= HDISP + HFP) && ((p % HT) < HDISP + HFP + HPULSE);
  endfunction

  function automatic bit in_vs(input int p);
    return ((p / HT) >= VDISP + VFP) && ((p / HT) < VDISP + VFP + VPULSE);
  endfunction

  function automatic bit exp_pop(input int p, input int mode, input logic empty);
    return (mode == 2) && is_act(p) && !empty;
  endfunction

  // 5-bit / 6-bit code scaled to 8 bits with the top bits copied below.
  function automatic logic [7:0] x5(input int v);
    return 8'((v << 3) | (v >> 2));
  endfunction

  function automatic logic [7:0] x6(input int v);
    return 8'((v << 2) | (v >> 4));
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_pos   <= 0;
      m_mode  <= 0;
      e_hs    <= 1'b1;
      e_vs    <= 1'b1;
      e_blank <= 1'b0;
      e_fs    <= 1'b0;
      e_uf    <= 1'b0;
      e_r     <= 8'd0;
      e_g     <= 8'd0;
      e_b     <= 8'd0;
    end else begin
      e_hs    <= !in_hs(m_pos);
      e_vs    <= !in_vs(m_pos);
      e_blank <= is_act(m_pos);
      e_fs    <= (m_pos == FR - 1);
      if (exp_pop(m_pos, m_mode, intf.fifo_rempty)) begin
        e_r <= x5((int'(intf.fifo_rdata) >> 11) & 31);
        e_g <= x6((int'(intf.fifo_rdata) >> 5) & 63);
        e_b <= x5(int'(intf.fifo_rdata) & 31);
      end else begin
        e_r <= 8'd0;
        e_g <= 8'd0;
        e_b <= 8'd0;
      end
      if (m_mode == 0) begin
        if (intf.fifo_rfull) m_mode <= 1;
      end else if (m_mode == 1) begin
        if (m_pos == FR - 1) m_mode <= 2;
      end else if (is_act(m_pos) && intf.fifo_rempty) begin
        m_mode <= 0;
        e_uf   <= 1'b1;
      end
      m_pos <= (m_pos + 1) % FR;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("fifo_read", int'(intf.fifo_read), int'(exp_pop(m_pos, m_mode, intf.fifo_rempty)));
      check("vga_HS", int'(vga_HS), int'(e_hs));
      check("vga_VS", int'(vga_VS), int'(e_vs));
      check("vga_BLANK", int'(vga_BLANK), int'(e_blank));
      check("vga_R", int'(vga_R), int'(e_r));
      check("vga_G", int'(vga_G), int'(e_g));
      check("vga_B", int'(vga_B), int'(e_b));
      check("frame_start", int'(frame_start), int'(e_fs));
      check("underflow", int'(underflow), int'(e_uf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts over n cycles, sampled just after each active edge.
  task automatic window(input int n, output int hs_lo, output int vs_lo,
                        output int fs, output int pops);
    hs_lo = 0; vs_lo = 0; fs = 0; pops = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (!vga_HS) hs_lo++;
      if (!vga_VS) vs_lo++;
      if (frame_start) fs++;
      if (intf.fifo_read) pops++;
      intf.fifo_rdata = 16'($urandom);
    end
  endtask

  task automatic wait_pop(input int limit, input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (intf.fifo_read) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no fifo_read within %0d cycles", name, limit);
    end
  endtask

  task automatic pulse_full();
    intf.fifo_rfull = 1'b1;
    step();
    intf.fifo_rfull = 1'b0;
  endtask

  task automatic colour(input logic [15:0] d, input int r, input int g, input int b);
    bit ok;
    intf.fifo_rdata = d;
    ok = intf.fifo_read;
    if (!ok) wait_pop(60, "colour_pop", ok);
    if (ok) begin
      step();
      check("colour_R", int'(vga_R), r);
      check("colour_G", int'(vga_G), g);
      check("colour_B", int'(vga_B), b);
    end
  endtask

  initial begin
    int hs_lo, vs_lo, fs, pops;
    bit ok;
    intf.fifo_rdata  = 16'h0000;
    intf.fifo_rempty = 1'b1;
    intf.fifo_rfull  = 1'b0;
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;

    // Reset values on the pins.
    @(negedge clk);
    check("rst_HS", int'(vga_HS), 1);
    check("rst_VS", int'(vga_VS), 1);
    check("rst_BLANK", int'(vga_BLANK), 0);
    check("rst_R", int'(vga_R), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_underflow", int'(underflow), 0);
    @(posedge clk);
    #1 n_rst = 1'b1;

    // FIFO never full: timing runs, nothing is popped.
    intf.fifo_rempty = 1'b0;
    window(FR, hs_lo, vs_lo, fs, pops);
    check("hs_low_per_frame", hs_lo, 12);
    check("vs_low_per_frame", vs_lo, 8);
    check("frames_per_48", fs, 1);
    check("pops_no_full", pops, 0);
    window(FR, hs_lo, vs_lo, fs, pops);
    check("pops_no_full_2", pops, 0);

    // Full pulse mid-frame: streaming starts exactly at the next frame start.
    repeat (13) step();
    pulse_full();
    wait_pop(2 * FR + 4, "first_pop", ok);
    if (ok) begin
      check("first_pop_at_sof", int'(frame_start), 1);
      window(FR - 1, hs_lo, vs_lo, fs, pops);
      check("pops_per_frame", pops + 1, HDISP * VDISP);
    end

    // Colour expansion.
    colour(16'hF800, 8'hFF, 8'h00, 8'h00);
    colour(16'h07E0, 8'h00, 8'hFF, 8'h00);
    colour(16'h0821, 8'h08, 8'h04, 8'h08);
    colour(16'h001F, 8'h00, 8'h00, 8'hFF);

    // Underflow at active pixel 2 of line 1.
    for (int i = 0; i < 2 * FR && m_pos != HT + 2; i++) step();
    check("uf_position", m_pos, HT + 2);
    intf.fifo_rempty = 1'b1;
    @(negedge clk);
    check("uf_no_pop", int'(intf.fifo_read), 0);
    step();
    intf.fifo_rempty = 1'b0;
    @(negedge clk);
    check("uf_rgb_zero", int'(vga_R) | int'(vga_G) | int'(vga_B), 0);
    check("uf_sticky", int'(underflow), 1);
    window(2 * FR, hs_lo, vs_lo, fs, pops);
    check("uf_no_pops_until_full", pops, 0);
    check("uf_still_set", int'(underflow), 1);
    pulse_full();
    wait_pop(2 * FR + 4, "resume_pop", ok);
    if (ok) check("resume_at_sof", int'(frame_start), 1);

    // Randomised traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 1600; i++) begin
      step();
      intf.fifo_rdata  = 16'($urandom);
      intf.fifo_rempty = (i < 800) ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 15) == 0);
      intf.fifo_rfull  = ($urandom_range(0, 40) == 0);
    end
    intf.fifo_rempty = 1'b0;
    intf.fifo_rfull  = 1'b0;

    // Asynchronous reset in the middle of an active line while streaming.
    pulse_full();
    wait_pop(2 * FR + 4, "pre_reset_pop", ok);
    repeat (2) step();
    n_rst = 1'b0;
    #1;
    check("arst_fifo_read", int'(intf.fifo_read), 0);
    check("arst_HS", int'(vga_HS), 1);
    check("arst_VS", int'(vga_VS), 1);
    check("arst_BLANK", int'(vga_BLANK), 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    window(FR - 1, hs_lo, vs_lo, fs, pops);
    check("post_rst_no_pops", pops, 0);
    check("post_rst_no_sof_yet", fs, 0);
    step();
    check("post_rst_sof_at_48", int'(frame_start), 1);
    check("post_rst_underflow", int'(underflow), 0);

    repeat (4) step();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
